xy_rr_arbiter: RTL and testbench

- Sequential, parametrised successor to the mesh router's combinational XY arbiter.
- Computes the dimension-ordered (X-first) route for the head flit of each of the 5 input FIFOs (N, E, S, W, L) on a MESH_X x MESH_Y mesh, with optional torus wrap.
- Each output port runs a round-robin arbiter with packet locking: an output stays owned by one input until that input's tail flit has transferred.
- Drives the input FIFO read enables and the output crossbar selects.

---
 rtl/xy_rr_arbiter_if.sv | 30 +++
 rtl/xy_rr_arbiter.sv | 169 ++++++++++++++++
 tb/tb_xy_rr_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xy_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : xy_rr_arbiter_if
// Purpose  : Input-FIFO head / output-port handshake bundle for xy_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface xy_rr_arbiter_if #(
    parameter int CW = 2
);
    logic [5*CW-1:0] dest_x;
    logic [5*CW-1:0] dest_y;
    logic [4:0]      tail;
    logic [4:0]      empty;
    logic [4:0]      out_ready;
    logic [4:0]      rd_en;
    logic [4:0]      out_valid;
    logic [14:0]     sel;
    logic [4:0]      busy;

    modport master (
        output dest_x, dest_y, tail, empty, out_ready,
        input  rd_en, out_valid, sel, busy
    );

    modport slave (
        input  dest_x, dest_y, tail, empty, out_ready,
        output rd_en, out_valid, sel, busy
    );
endinterface
`default_nettype wire

// File: rtl/xy_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : xy_rr_arbiter
// Purpose  : X-first route plus per-output round-robin arbiter with packet lock.
// Revision : 1.0 - initial release
// ============================================================================
module xy_rr_arbiter #(
    parameter int MESH_X = 4,
    parameter int MESH_Y = 4,
    parameter int CW     = 2,
    parameter int TORUS  = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic [CW-1:0] X,
    input  wire logic [CW-1:0] Y,
    xy_rr_arbiter_if.slave     bus
);

    localparam logic [CW:0] c_MX     = (CW+1)'(MESH_X);
    localparam logic [CW:0] c_MY     = (CW+1)'(MESH_Y);
    localparam logic [CW:0] c_HALF_X = (CW+1)'(MESH_X / 2);
    localparam logic [CW:0] c_HALF_Y = (CW+1)'(MESH_Y / 2);

    localparam logic [2:0] c_PORT_N = 3'd0;
    localparam logic [2:0] c_PORT_E = 3'd1;
    localparam logic [2:0] c_PORT_S = 3'd2;
    localparam logic [2:0] c_PORT_W = 3'd3;
    localparam logic [2:0] c_PORT_L = 3'd4;

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_LOCKED = 1'b1;

    logic [14:0] w_route;
    logic [4:0]  w_locked;
    logic [14:0] w_owner;
    logic [4:0]  w_xfer;
    logic [14:0] w_sel;
    logic [4:0]  w_owned;
    logic [4:0]  w_rd_en;

    // Modular offsets are formed with one extra bit so non-power-of-two meshes wrap correctly.
    for (genvar i = 0; i < 5; i++) begin : g_route
        logic [CW:0] w_dst_x;
        logic [CW:0] w_dst_y;
        logic [CW:0] w_dx;
        logic [CW:0] w_dy;
        logic [2:0]  w_dir;

        always_comb begin
            w_dst_x = {1'b0, bus.dest_x[i*CW +: CW]};
            w_dst_y = {1'b0, bus.dest_y[i*CW +: CW]};
            w_dx    = (w_dst_x >= {1'b0, X}) ? (w_dst_x - {1'b0, X})
                                             : (w_dst_x + c_MX - {1'b0, X});
            w_dy    = (w_dst_y >= {1'b0, Y}) ? (w_dst_y - {1'b0, Y})
                                             : (w_dst_y + c_MY - {1'b0, Y});
            w_dir   = c_PORT_L;
            if (w_dx != '0) begin
                if (TORUS != 0) w_dir = (w_dx <= c_HALF_X) ? c_PORT_E : c_PORT_W;
                else            w_dir = (w_dst_x > {1'b0, X}) ? c_PORT_E : c_PORT_W;
            end else if (w_dy != '0) begin
                if (TORUS != 0) w_dir = (w_dy <= c_HALF_Y) ? c_PORT_S : c_PORT_N;
                else            w_dir = (w_dst_y > {1'b0, Y}) ? c_PORT_S : c_PORT_N;
            end
        end

        assign w_route[i*3 +: 3] = w_dir;
    end

    // An input can be owned by at most one output because its head routes to one port only.
    always_comb begin
        w_owned = '0;
        w_rd_en = '0;
        for (int o = 0; o < 5; o++) begin
            if (w_locked[o]) begin
                w_owned[w_owner[o*3 +: 3]] = 1'b1;
                if (w_xfer[o]) w_rd_en[w_owner[o*3 +: 3]] = 1'b1;
            end
        end
    end

    for (genvar o = 0; o < 5; o++) begin : g_out
        localparam logic [2:0] c_SELF = 3'(o);

        logic [0:0] r_state;
        logic [0:0] w_state_nx;
        logic [2:0] r_owner;
        logic [2:0] w_owner_nx;
        logic [2:0] r_ptr;
        logic [2:0] w_ptr_nx;
        logic [4:0] w_req;
        logic [2:0] w_pick;
        logic       w_found;
        logic [3:0] w_sum;
        logic [2:0] w_idx;
        logic       w_xfer_o;

        always_comb begin
            w_req = '0;
            for (int i = 0; i < 5; i++) begin
                w_req[i] = ~bus.empty[i] & (w_route[i*3 +: 3] == c_SELF)
                         & ~w_owned[i] & (i != o);
            end
        end

        // Cyclic scan starting at the pointer; the first hit wins.
        always_comb begin
            w_found = 1'b0;
            w_pick  = r_ptr;
            w_sum   = '0;
            w_idx   = '0;
            for (int k = 0; k < 5; k++) begin
                w_sum = {1'b0, r_ptr} + 4'(k);
                w_idx = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : 3'(w_sum);
                if (!w_found && w_req[w_idx]) begin
                    w_found = 1'b1;
                    w_pick  = w_idx;
                end
            end
        end

        always_comb begin
            w_state_nx = r_state;
            w_owner_nx = r_owner;
            w_ptr_nx   = r_ptr;
            w_xfer_o   = 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        w_state_nx = c_LOCKED;
                        w_owner_nx = w_pick;
                    end
                end
                c_LOCKED: begin
                    w_xfer_o = ~bus.empty[r_owner] & bus.out_ready[o];
                    if (w_xfer_o && bus.tail[r_owner]) begin
                        w_state_nx = c_IDLE;
                        w_ptr_nx   = (r_owner == 3'd4) ? 3'd0 : (r_owner + 3'd1);
                    end
                end
                default: w_state_nx = c_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= c_IDLE;
                r_owner <= '0;
                r_ptr   <= '0;
            end else begin
                r_state <= w_state_nx;
                r_owner <= w_owner_nx;
                r_ptr   <= w_ptr_nx;
            end
        end

        assign w_locked[o]        = (r_state == c_LOCKED);
        assign w_owner[o*3 +: 3]  = r_owner;
        assign w_xfer[o]          = w_xfer_o;
        assign w_sel[o*3 +: 3]    = (r_state == c_LOCKED) ? r_owner : 3'd0;
    end

    assign bus.rd_en     = w_rd_en;
    assign bus.out_valid = w_xfer;
    assign bus.busy      = w_locked;
    assign bus.sel       = w_sel;

endmodule
`default_nettype wire

// File: tb/tb_xy_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_xy_rr_arbiter
// Purpose  : Directed and random self-checking bench for xy_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xy_rr_arbiter;

    localparam int MESH_X = 4;
    localparam int MESH_Y = 4;
    localparam int CW     = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] X;
    logic [CW-1:0] Y;

    xy_rr_arbiter_if #(.CW(CW)) bus_t ();
    xy_rr_arbiter_if #(.CW(CW)) bus_m ();

    assign bus_m.dest_x    = bus_t.dest_x;
    assign bus_m.dest_y    = bus_t.dest_y;
    assign bus_m.tail      = bus_t.tail;
    assign bus_m.empty     = bus_t.empty;
    assign bus_m.out_ready = bus_t.out_ready;

    xy_rr_arbiter #(.MESH_X(MESH_X), .MESH_Y(MESH_Y), .CW(CW), .TORUS(1)) dut_t (
        .clk(clk), .rst_n(rst_n), .X(X), .Y(Y), .bus(bus_t.slave)
    );

    xy_rr_arbiter #(.MESH_X(MESH_X), .MESH_Y(MESH_Y), .CW(CW), .TORUS(0)) dut_m (
        .clk(clk), .rst_n(rst_n), .X(X), .Y(Y), .bus(bus_m.slave)
    );

    always #5 clk = ~clk;

    // Flits are packed as dx | dy<<8 | tail<<16; each queue is one input FIFO.
    int         q[5][$];
    int         grants[5][$];
    int         m_owner[5];
    int         m_ptr[5];
    logic [4:0] hold;
    logic [4:0] ready;
    logic [4:0] cur_empty;
    logic [4:0] cur_ready;
    logic [4:0] prev_busy;
    int         n_checks = 0;
    int         n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int route(input int dxd, input int dyd);
        int dx;
        int dy;
        dx = ((dxd - int'(X)) % MESH_X + MESH_X) % MESH_X;
        dy = ((dyd - int'(Y)) % MESH_Y + MESH_Y) % MESH_Y;
        if (dx != 0) return (dx <= MESH_X / 2) ? 1 : 3;
        if (dy != 0) return (dy <= MESH_Y / 2) ? 2 : 0;
        return 4;
    endfunction

    task automatic push(input int i, input int dx, input int dy, input int t);
        q[i].push_back(dx | (dy << 8) | (t << 16));
    endtask

    task automatic push_pkt(input int i, input int dx, input int dy, input int len);
        push(i, dx, dy, (len == 1) ? 1 : 0);
        for (int k = 1; k < len; k++)
            push(i, $urandom_range(0, MESH_X - 1), $urandom_range(0, MESH_Y - 1),
                 (k == len - 1) ? 1 : 0);
    endtask

    task automatic drive();
        logic [5*CW-1:0] dxv;
        logic [5*CW-1:0] dyv;
        logic [4:0]      tl;
        logic [4:0]      em;
        int              f;
        dxv = '0; dyv = '0; tl = '0; em = '1;
        for (int i = 0; i < 5; i++) begin
            if (q[i].size() > 0) begin
                f                  = q[i][0];
                dxv[i*CW +: CW]    = CW'(f & 255);
                dyv[i*CW +: CW]    = CW'((f >> 8) & 255);
                tl[i]              = f[16];
                em[i]              = hold[i];
            end
        end
        bus_t.dest_x    = dxv;
        bus_t.dest_y    = dyv;
        bus_t.tail      = tl;
        bus_t.empty     = em;
        bus_t.out_ready = ready;
        cur_empty       = em;
        cur_ready       = ready;
    endtask

    task automatic model_check();
        logic [4:0]  rd;
        logic [4:0]  ov;
        logic [4:0]  bz;
        logic [14:0] sl;
        rd = '0; ov = '0; bz = '0; sl = '0;
        for (int o = 0; o < 5; o++) begin
            if (m_owner[o] >= 0) begin
                bz[o]          = 1'b1;
                sl[o*3 +: 3]   = 3'(m_owner[o]);
                if (!cur_empty[m_owner[o]] && cur_ready[o]) begin
                    ov[o]          = 1'b1;
                    rd[m_owner[o]] = 1'b1;
                end
            end
        end
        chk("rd_en", 32'(bus_t.rd_en), 32'(rd));
        chk("out_valid", 32'(bus_t.out_valid), 32'(ov));
        chk("busy", 32'(bus_t.busy), 32'(bz));
        chk("sel", 32'(bus_t.sel), 32'(sl));
        for (int o = 0; o < 5; o++)
            if (bus_t.busy[o] && !prev_busy[o]) grants[o].push_back(int'(bus_t.sel[o*3 +: 3]));
        prev_busy = bus_t.busy;
    endtask

    task automatic model_seq();
        int  old[5];
        int  f;
        int  c;
        bit  taken;
        bit  owned;
        old = m_owner;
        for (int o = 0; o < 5; o++) begin
            if (old[o] >= 0) begin
                if (!cur_empty[old[o]] && cur_ready[o]) begin
                    f = q[old[o]].pop_front();
                    if (f[16]) begin
                        m_owner[o] = -1;
                        m_ptr[o]   = (old[o] + 1) % 5;
                    end
                end
            end else begin
                taken = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    c     = (m_ptr[o] + k) % 5;
                    owned = 1'b0;
                    for (int p = 0; p < 5; p++) if (old[p] == c) owned = 1'b1;
                    if (!taken && !cur_empty[c] && c != o && !owned &&
                        route(q[c][0] & 255, (q[c][0] >> 8) & 255) == o) begin
                        m_owner[o] = c;
                        taken      = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic eval();
        drive();
        #1;
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_seq();
        @(negedge clk);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            eval();
            advance();
        end
    endtask

    task automatic do_reset(input int x, input int y);
        rst_n = 1'b0;
        X     = CW'(x);
        Y     = CW'(y);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            q[i].delete();
            grants[i].delete();
            m_owner[i] = -1;
            m_ptr[i]   = 0;
        end
        prev_busy = '0;
        hold      = '0;
        ready     = '1;
        chk("xy_legal", 32'((int'(X) < MESH_X) && (int'(Y) < MESH_Y)), 32'd1);
    endtask

    task automatic route_case(input int src, input int dx, input int dy,
                              input int exp_t, input int exp_m);
        logic [5*CW-1:0] dxv;
        logic [5*CW-1:0] dyv;
        dxv = '0; dyv = '0;
        dxv[src*CW +: CW] = CW'(dx);
        dyv[src*CW +: CW] = CW'(dy);
        bus_t.dest_x    = dxv;
        bus_t.dest_y    = dyv;
        bus_t.tail      = 5'b11111;
        bus_t.empty     = ~(5'b00001 << src);
        bus_t.out_ready = 5'b11111;
        @(posedge clk);
        #1;
        chk("route_torus", 32'(bus_t.busy), 32'd1 << exp_t);
        chk("route_mesh", 32'(bus_m.busy), 32'd1 << exp_m);
        @(posedge clk);
        @(negedge clk);
        bus_t.empty = 5'b11111;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rr[4];
        int rd4;
        int src;
        int dx;
        int dy;
        int left;
        int guard;

        rst_n = 1'b1;
        X = '0; Y = '0;
        hold = '0; ready = '1; prev_busy = '0;
        bus_t.dest_x = '0; bus_t.dest_y = '0; bus_t.tail = '0;
        bus_t.empty = '1; bus_t.out_ready = '1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", 32'(bus_t.busy), 32'd0);
        chk("reset_sel", 32'(bus_t.sel), 32'd0);
        chk("reset_rd_en", 32'(bus_t.rd_en), 32'd0);
        chk("reset_out_valid", 32'(bus_t.out_valid), 32'd0);
        chk("reset_busy_mesh", 32'(bus_m.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Route table at (0,0): torus / plain mesh expectations.
        @(negedge clk);
        route_case(4, 3, 0, 3, 1);
        route_case(4, 2, 0, 1, 1);
        route_case(4, 0, 3, 0, 2);
        route_case(4, 0, 1, 2, 2);
        route_case(0, 0, 0, 4, 4);

        do_reset(1, 1);

        // Round robin from pointer 0.
        push_pkt(0, 2, 1, 1); push_pkt(2, 2, 1, 1);
        push_pkt(3, 2, 1, 1); push_pkt(4, 2, 1, 1);
        cyc(9);
        exp_rr = '{0, 2, 3, 4};
        chk("rr0_count", 32'(grants[1].size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < grants[1].size()) chk("rr0_order", 32'(grants[1][k]), 32'(exp_rr[k]));

        // Round robin from pointer 3.
        push_pkt(2, 2, 1, 1);
        cyc(3);
        grants[1].delete();
        push_pkt(0, 2, 1, 1); push_pkt(2, 2, 1, 1);
        push_pkt(3, 2, 1, 1); push_pkt(4, 2, 1, 1);
        cyc(9);
        exp_rr = '{3, 4, 0, 2};
        chk("rr3_count", 32'(grants[1].size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < grants[1].size()) chk("rr3_order", 32'(grants[1][k]), 32'(exp_rr[k]));

        // Packet lock: 3 flits from W to E (torus tie), body dest ignored.
        push(3, 3, 1, 0); push(3, 0, 0, 0); push(3, 1, 2, 1);
        for (int s = 0; s < 5; s++) begin
            eval();
            chk("lock_busyE", 32'(bus_t.busy[1]), 32'(s >= 1 && s <= 3));
            chk("lock_rdW", 32'(bus_t.rd_en[3]), 32'(s >= 1 && s <= 3));
            if (s == 2) chk("lock_selE", 32'(bus_t.sel[5:3]), 32'd3);
            advance();
        end

        // Backpressure on E for 4 cycles mid-packet.
        push_pkt(4, 2, 1, 6);
        rd4 = 0;
        for (int s = 0; s < 12; s++) begin
            ready[1] = !(s >= 3 && s <= 6);
            eval();
            if (!ready[1]) begin
                chk("bp_stall_rd", 32'(bus_t.rd_en[4]), 32'd0);
                chk("bp_stall_lock", 32'(bus_t.busy[1]), 32'd1);
            end
            rd4 += int'(bus_t.rd_en[4]);
            advance();
        end
        chk("bp_flits", 32'(rd4), 32'd6);
        ready = '1;

        // Concurrency: N->S, E->W in parallel; L->L is a dropped U-turn.
        push_pkt(0, 1, 2, 1); push_pkt(1, 0, 1, 1); push_pkt(4, 1, 1, 1);
        cyc(1);
        eval();
        chk("conc_busy", 32'(bus_t.busy), 32'h0c);
        chk("conc_rd_en", 32'(bus_t.rd_en), 32'h03);
        advance();
        cyc(2);
        q[4].delete();
        push_pkt(1, 2, 1, 1);
        for (int s = 0; s < 3; s++) begin
            eval();
            chk("uturn_busy", 32'(bus_t.busy), 32'd0);
            advance();
        end
        q[1].delete();

        // Mid-packet async reset with ptr[E] moved away from 0 beforehand.
        push_pkt(3, 2, 1, 1);
        cyc(3);
        push_pkt(0, 2, 1, 4);
        cyc(3);
        eval();
        chk("pre_reset_busyE", 32'(bus_t.busy[1]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(bus_t.busy), 32'd0);
        chk("async_sel", 32'(bus_t.sel), 32'd0);
        chk("async_rd_en", 32'(bus_t.rd_en), 32'd0);
        chk("async_out_valid", 32'(bus_t.out_valid), 32'd0);
        do_reset(1, 1);
        push_pkt(4, 2, 1, 1); push_pkt(0, 2, 1, 1);
        cyc(5);
        chk("post_reset_count", 32'(grants[1].size()), 32'd2);
        if (grants[1].size() > 0) chk("post_reset_first", 32'(grants[1][0]), 32'd0);

        // Random traffic at another router position.
        do_reset($urandom_range(0, MESH_X - 1), $urandom_range(0, MESH_Y - 1));
        for (int s = 0; s < 600; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                src = $urandom_range(0, 4);
                if (q[src].size() < 6) begin
                    do begin
                        dx = $urandom_range(0, MESH_X - 1);
                        dy = $urandom_range(0, MESH_Y - 1);
                    end while (route(dx, dy) == src);
                    push_pkt(src, dx, dy, $urandom_range(1, 4));
                end
            end
            for (int i = 0; i < 5; i++) begin
                hold[i]  = ($urandom_range(0, 4) == 0);
                ready[i] = ($urandom_range(0, 3) != 0);
            end
            cyc(1);
        end
        hold  = '0;
        ready = '1;
        guard = 0;
        left  = 1;
        while (left != 0 && guard < 300) begin
            cyc(1);
            guard++;
            left = 0;
            for (int i = 0; i < 5; i++) left += q[i].size() + ((m_owner[i] >= 0) ? 1 : 0);
        end
        chk("drain_left", 32'(left), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
